// File: rtl/csa.sv
// -----------------------------------------------------------------------------
// csa -- parameterised carry-select adder with registered copy of the result.
//
// Parameters
//   N    : operand width in bits (1..32)
//   BLK  : carry-select block width in bits (1..N); the top block is narrower
//          when N is not a multiple of BLK
//
// Ports (positional order is fixed)
//   a, b   : unsigned operands, N bits
//   ci     : carry in
//   sum    : combinational sum, bits N-1:0 of a+b+ci
//   co     : combinational carry out, bit N of a+b+ci
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset (clears the registered outputs only)
//   sum_q  : sum registered on each rising clk edge
//   co_q   : co registered on each rising clk edge
//   ovf    : (CSA_OVF_EN only) signed two's-complement overflow of a+b+ci
//   ovf_q  : (CSA_OVF_EN only) registered ovf
//
// Optional feature: define the macro CSA_OVF_EN to add the ovf/ovf_q ports.
// Without it the port list ends at co_q.
// -----------------------------------------------------------------------------
module csa #(
  parameter int N   = 3,
  parameter int BLK = 2
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] sum,
  output logic         co,
  input  logic         clk,
  input  logic         rst_n,
  output logic [N-1:0] sum_q,
  output logic         co_q
`ifdef CSA_OVF_EN
  ,
  output logic         ovf,
  output logic         ovf_q
`endif
);

  // Number of carry-select blocks, rounding up so a partial top block exists.
  localparam int NB = (N + BLK - 1) / BLK;

  // Full-adder cell: returns {cout, s}. Plain logic operators, so X/Z on an
  // input propagates to the outputs instead of being masked.
  function automatic logic [1:0] fa(input logic x, input logic y, input logic c);
    fa = {(x & y) | (x & c) | (y & c), x ^ y ^ c};
  endfunction

  // Carry entering each block; blk_c_s[NB] is the adder's carry out.
  logic [NB:0] blk_c_s;

  assign blk_c_s[0] = ci;

  for (genvar k = 0; k < NB; k++) begin : g_blk
    localparam int LO = k * BLK;
    localparam int HI = ((LO + BLK) > N) ? (N - 1) : (LO + BLK - 1);
    localparam int W  = HI - LO + 1;

    if (k == 0) begin : g_first
      // Block 0 is a single ripple chain fed straight from ci.
      logic [W:0]   c_s;
      logic [W-1:0] s_s;

      assign c_s[0] = blk_c_s[0];
      for (genvar j = 0; j < W; j++) begin : g_bit
        assign {c_s[j+1], s_s[j]} = fa(a[LO+j], b[LO+j], c_s[j]);
      end
      assign sum[HI:LO]   = s_s;
      assign blk_c_s[k+1] = c_s[W];
    end else begin : g_sel
      // Higher blocks precompute both carry-in cases, then the previous
      // block's carry picks one; this keeps the long carry path to one mux
      // per block.
      logic [W:0]   c0_s;
      logic [W:0]   c1_s;
      logic [W-1:0] s0_s;
      logic [W-1:0] s1_s;

      assign c0_s[0] = 1'b0;
      assign c1_s[0] = 1'b1;
      for (genvar j = 0; j < W; j++) begin : g_bit
        assign {c0_s[j+1], s0_s[j]} = fa(a[LO+j], b[LO+j], c0_s[j]);
        assign {c1_s[j+1], s1_s[j]} = fa(a[LO+j], b[LO+j], c1_s[j]);
      end
      assign sum[HI:LO]   = blk_c_s[k] ? s1_s : s0_s;
      assign blk_c_s[k+1] = blk_c_s[k] ? c1_s[W] : c0_s[W];
    end
  end

  assign co = blk_c_s[NB];

`ifdef CSA_OVF_EN
  // The carry into the MSB is recovered as a^b^sum at that bit; signed
  // overflow is that carry disagreeing with the carry out.
  assign ovf = (a[N-1] ^ b[N-1] ^ sum[N-1]) ^ co;
`endif

  // Next-state values for the registered copies.
  logic [N-1:0] sum_d;
  logic         co_d;
`ifdef CSA_OVF_EN
  logic         ovf_d;
`endif

  // Register next-state: follow the combinational result.
  always_comb begin
    sum_d = sum;
    co_d  = co;
`ifdef CSA_OVF_EN
    ovf_d = ovf;
`endif
  end

  // Result registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q <= {N{1'b0}};
      co_q  <= 1'b0;
`ifdef CSA_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else begin
      sum_q <= sum_d;
      co_q  <= co_d;
`ifdef CSA_OVF_EN
      ovf_q <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_csa.sv
// -----------------------------------------------------------------------------
// tb_csa -- self-checking bench for csa.
// Instances: N=3/BLK=2 (exhaustive + registered path), N=8/BLK=3 (uneven top
// block), and with CSA_OVF_EN an N=4/BLK=2 instance for the overflow flag.
// -----------------------------------------------------------------------------
module tb_csa;

  logic clk;
  logic rst_n;

  // N=3 instance
  logic [2:0] a3, b3, s3, s3_q;
  logic       ci3, co3, co3_q;
  // N=8 instance
  logic [7:0] a8, b8, s8, s8_q;
  logic       ci8, co8, co8_q;

  int n_checks;
  int n_errors;

  csa #(.N(3), .BLK(2)) u_dut3 (
    .a(a3), .b(b3), .ci(ci3), .sum(s3), .co(co3),
    .clk(clk), .rst_n(rst_n), .sum_q(s3_q), .co_q(co3_q)
`ifdef CSA_OVF_EN
    , .ovf(), .ovf_q()
`endif
  );

  csa #(.N(8), .BLK(3)) u_dut8 (
    .a(a8), .b(b8), .ci(ci8), .sum(s8), .co(co8),
    .clk(clk), .rst_n(rst_n), .sum_q(s8_q), .co_q(co8_q)
`ifdef CSA_OVF_EN
    , .ovf(), .ovf_q()
`endif
  );

`ifdef CSA_OVF_EN
  logic [3:0] a4, b4, s4, s4_q;
  logic       ci4, co4, co4_q, ovf4, ovf4_q;

  csa #(.N(4), .BLK(2)) u_dut4 (
    .a(a4), .b(b4), .ci(ci4), .sum(s4), .co(co4),
    .clk(clk), .rst_n(rst_n), .sum_q(s4_q), .co_q(co4_q),
    .ovf(ovf4), .ovf_q(ovf4_q)
  );
`endif

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int loops;
    logic [3:0] ref3;

    n_checks = 0;
    n_errors = 0;
    loops    = 0;
    rst_n = 1'b0;
    a3 = 3'd5; b3 = 3'd3; ci3 = 1'b0;
    a8 = 8'd0; b8 = 8'd0; ci8 = 1'b0;
`ifdef CSA_OVF_EN
    a4 = 4'd0; b4 = 4'd0; ci4 = 1'b0;
`endif

    // Reset held for two edges
    repeat (2) @(posedge clk);
    #1;
    check("rst_sum_q", {30'd0, s3_q}, 33'd0);
    check("rst_co_q",  {32'd0, co3_q}, 33'd0);
    // Combinational path ignores reset: 5+3 = 8
    check("rst_comb_sum", {30'd0, s3}, 33'd0);
    check("rst_comb_co",  {32'd0, co3}, 33'd1);

    // Exhaustive N=3
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        for (int c = 0; c < 2; c++) begin
          a3 = i[2:0]; b3 = j[2:0]; ci3 = c[0];
          #5;
          ref3 = 4'(i) + 4'(j) + 4'(c);
          check("exh3", {29'd0, co3, s3}, {29'd0, ref3});
          loops++;
        end
      end
    end
    check("exh3_count", 33'(loops), 33'd128);

    // Directed N=3 corners
    a3 = 3'd7; b3 = 3'd7; ci3 = 1'b1; #5;
    check("n3_ones_sum", {30'd0, s3}, 33'd7);
    check("n3_ones_co",  {32'd0, co3}, 33'd1);
    a3 = 3'd4; b3 = 3'd4; ci3 = 1'b0; #5;
    check("n3_wrap_sum", {30'd0, s3}, 33'd0);
    check("n3_wrap_co",  {32'd0, co3}, 33'd1);
    a3 = 3'd0; b3 = 3'd0; ci3 = 1'b0; #5;
    check("n3_zero", {29'd0, co3, s3}, 33'd0);
    // Registers still held in reset
    check("rst_hold_sum_q", {29'd0, co3_q, s3_q}, 33'd0);

    // Directed N=8, BLK=3
    a8 = 8'hFF; b8 = 8'h01; ci8 = 1'b0; #5;
    check("n8_ff_01", {24'd0, co8, s8}, 33'h100);
    a8 = 8'h80; b8 = 8'h7F; ci8 = 1'b1; #5;
    check("n8_80_7f_c", {24'd0, co8, s8}, 33'h100);
    a8 = 8'h12; b8 = 8'h34; ci8 = 1'b0; #5;
    check("n8_12_34", {24'd0, co8, s8}, 33'h046);
    a8 = 8'h55; b8 = 8'hAA; ci8 = 1'b0; #5;
    check("n8_55_aa", {24'd0, co8, s8}, 33'h0FF);
    a8 = 8'h07; b8 = 8'h01; ci8 = 1'b1; #5;
    check("n8_blk_carry", {24'd0, co8, s8}, 33'h009);
    a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1; #5;
    check("n8_ones", {24'd0, co8, s8}, 33'h1FF);

`ifdef CSA_OVF_EN
    a4 = 4'd7; b4 = 4'd1; ci4 = 1'b0; #5;
    check("ovf_7_1", {32'd0, ovf4}, 33'd1);
    check("ovf_7_1_co", {32'd0, co4}, 33'd0);
    a4 = 4'd8; b4 = 4'd8; ci4 = 1'b0; #5;
    check("ovf_8_8", {32'd0, ovf4}, 33'd1);
    check("ovf_8_8_co", {32'd0, co4}, 33'd1);
    a4 = 4'd3; b4 = 4'd2; ci4 = 1'b0; #5;
    check("ovf_3_2", {32'd0, ovf4}, 33'd0);
    a4 = 4'd15; b4 = 4'd1; ci4 = 1'b0; #5;
    check("ovf_f_1", {32'd0, ovf4}, 33'd0);
    check("ovf_f_1_co", {32'd0, co4}, 33'd1);
    a4 = 4'd7; b4 = 4'd1; ci4 = 1'b0;
`endif

    // Registered path: release reset with 5+3 applied
    @(negedge clk);
    rst_n = 1'b1;
    a3 = 3'd5; b3 = 3'd3; ci3 = 1'b0;
    @(posedge clk); #1;
    check("reg_first_sum_q", {30'd0, s3_q}, 33'd0);
    check("reg_first_co_q",  {32'd0, co3_q}, 33'd1);
`ifdef CSA_OVF_EN
    check("reg_ovf_q", {32'd0, ovf4_q}, 33'd1);
`endif

    // New inputs must not appear before the next edge: 2+3+1 = 6
    @(negedge clk);
    a3 = 3'd2; b3 = 3'd3; ci3 = 1'b1;
    #1;
    check("reg_latency_sum_q", {29'd0, co3_q, s3_q}, 33'h8);
    @(posedge clk); #1;
    check("reg_next_sum_q", {29'd0, co3_q, s3_q}, 33'h6);

    // Mid-stream reset discards the pending result
    @(negedge clk);
    rst_n = 1'b0;
    a3 = 3'd7; b3 = 3'd7; ci3 = 1'b0;
    @(posedge clk); #1;
    check("reg_mid_rst", {29'd0, co3_q, s3_q}, 33'd0);
    check("reg_mid_rst_comb", {29'd0, co3, s3}, 33'hE);
`ifdef CSA_OVF_EN
    check("reg_mid_rst_ovf_q", {32'd0, ovf4_q}, 33'd0);
`endif

    // First edge after deassertion loads the current result
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("reg_reload", {29'd0, co3_q, s3_q}, 33'hE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/csa.md
CSA -- requirements
Module: csa

Interface
- REQ-001 Parameter N, default 3: operand width in bits; first positional parameter; legal range 1..32.
- REQ-002 Parameter BLK, default 2: carry-select block width in bits; legal range 1..N.
- REQ-003 Port clk, input, 1: single clock; all registers update on its rising edge.
- REQ-004 Port rst_n, input, 1: reset, synchronous and active-low.
- REQ-005 Port a, input, N: operand A, unsigned.
- REQ-006 Port b, input, N: operand B, unsigned.
- REQ-007 Port ci, input, 1: carry in.
- REQ-008 Port sum, output, N: combinational sum, bits N-1:0 of a+b+ci.
- REQ-009 Port co, output, 1: combinational carry out, bit N of a+b+ci.
- REQ-010 Port sum_q, output, N: registered copy of sum.
- REQ-011 Port co_q, output, 1: registered copy of co.
- REQ-012 Positional port order is fixed as a, b, ci, sum, co, clk, rst_n, sum_q, co_q, so a five-port positional instance binds the adder ports.

Function
- REQ-013 {co,sum} SHALL equal a+b+ci exactly, as an (N+1)-bit result, for all 2^(2N+1) input combinations.
- REQ-014 sum/co SHALL be purely combinational: zero cycles of latency, no dependence on clk or rst_n, settled within one simulation step of an input change.
- REQ-015 The adder SHALL be built as a carry-select structure:
  - operands are split into ceil(N/BLK) blocks starting at bit 0;
  - the last block is narrower when N mod BLK is not 0;
  - block 0 is a ripple of full adders fed directly by ci;
  - each higher block computes two ripple sums, one with carry-in 0 and one with carry-in 1;
  - each higher block selects its sum and carry with a 2:1 mux driven by the previous block's carry.
- REQ-016 Full-adder cells SHALL obey s = x^y^c and cout = xy | xc | yc.
- REQ-017 Boundary cases:
  - a=b=all-ones, ci=1 -> sum all-ones, co=1;
  - a=b=0, ci=0 -> sum=0, co=0;
  - wrap-around is reported only through co, with no saturation.
- REQ-018 sum_q/co_q SHALL capture sum/co on each rising clk edge while rst_n=1, giving one cycle of latency.
- REQ-019 X or Z on any input bit SHALL NOT be masked; the affected outputs may go X.

Reset
- REQ-020 While rst_n=0 at a rising clk edge, sum_q SHALL be 0 and co_q SHALL be 0 after that edge (also ovf_q=0 when present).
- REQ-021 Reset SHALL NOT affect sum/co.
- REQ-022 On deassertion, the first edge with rst_n=1 SHALL load the current result.
- REQ-023 If reset is asserted mid-stream, the pending result is discarded.

Configuration
- REQ-024 Macro CSA_OVF_EN:
  - when defined, adds output ovf (1 bit, appended after co_q), equal to the two's-complement signed overflow of a+b+ci, i.e. carry into MSB XOR co;
  - when defined, also adds registered ovf_q, same timing and reset as co_q;
  - when undefined, ovf/ovf_q do not exist and the port list is exactly REQ-012.

Verification
- REQ-025 Exhaustive, N=3, BLK=2: all a, b in 0..7 and ci in 0..1, 5 ns settle each -> {co,sum} === a+b+ci in all 128 cases, and the loop executed at least once.
- REQ-026 N=3: a=7, b=7, ci=1 -> sum=7, co=1; a=4, b=4, ci=0 -> sum=0, co=1.
- REQ-027 N=8, BLK=3 (uneven last block): a=0xFF, b=0x01, ci=0 -> sum=0x00, co=1; a=0x80, b=0x7F, ci=1 -> sum=0x00, co=1.
- REQ-028 Registered path: rst_n=0 for 2 edges -> sum_q=0, co_q=0; then rst_n=1, a=5, b=3, ci=0 -> after next edge sum_q=0, co_q=1; rst_n=0 mid-stream -> 0 after next edge.
- REQ-029 With CSA_OVF_EN, N=4: a=7, b=1, ci=0 -> ovf=1; a=8, b=8, ci=0 -> ovf=1, co=1; a=3, b=2, ci=0 -> ovf=0.
